// File: rtl/second_chance_ctrl_if.sv
// second_chance_ctrl_if
//   Request/response handshake plus the cell-array bus of the second-chance
//   replacement controller, bundled as one interface.
//   slave  : the controller side (takes requests and cell flags, drives the
//            response and the cell strobes).
//   master : the requester/cell-array side (the mirror image).
//   Signals: req_valid_i/req_op_i/req_key_i/req_ready_o     request handshake
//            resp_valid_o/resp_hit_o/resp_idx_o/resp_evict_o response strobe
//            cell_empty_i/cell_hit_i                        per-cell flags
//            cell_cs_o/cell_we_o/cell_del_o                 cell strobes
//            key_write_o/key_read_o                         key to the cells
interface second_chance_ctrl_if #(
  parameter int KEY_WIDTH = 32,
  parameter int NUM_CELLS = 4
);
  localparam int IDX_W = $clog2(NUM_CELLS);

  logic                 req_valid_i;
  logic [1:0]           req_op_i;
  logic [KEY_WIDTH-1:0] req_key_i;
  logic                 req_ready_o;

  logic                 resp_valid_o;
  logic                 resp_hit_o;
  logic [IDX_W-1:0]     resp_idx_o;
  logic                 resp_evict_o;

  logic [NUM_CELLS-1:0] cell_empty_i;
  logic [NUM_CELLS-1:0] cell_hit_i;
  logic [NUM_CELLS-1:0] cell_cs_o;
  logic                 cell_we_o;
  logic                 cell_del_o;
  logic [KEY_WIDTH-1:0] key_write_o;
  logic [KEY_WIDTH-1:0] key_read_o;

  modport slave (
    input  req_valid_i, req_op_i, req_key_i, cell_empty_i, cell_hit_i,
    output req_ready_o, resp_valid_o, resp_hit_o, resp_idx_o, resp_evict_o,
           cell_cs_o, cell_we_o, cell_del_o, key_write_o, key_read_o
  );

  modport master (
    output req_valid_i, req_op_i, req_key_i, cell_empty_i, cell_hit_i,
    input  req_ready_o, resp_valid_o, resp_hit_o, resp_idx_o, resp_evict_o,
           cell_cs_o, cell_we_o, cell_del_o, key_write_o, key_read_o
  );
endinterface

// File: rtl/second_chance_ctrl.sv
// second_chance_ctrl
//   Lookup/insert/delete controller for a small fully associative key table
//   using second-chance (clock) replacement. The cells themselves live
//   outside; this block compares through cell_hit_i/cell_empty_i and writes
//   or deletes a cell with a one-cycle select/strobe.
//   Ports: clk    rising-edge clock
//          reset  asynchronous active-low reset
//          bus    second_chance_ctrl_if.slave (request, response, cell bus)
//          stat_hit_o/stat_evict_o  saturating hit/eviction counters,
//                                   present only when SC_STATS_EN is defined
//   Optional feature macro: SC_STATS_EN
module second_chance_ctrl #(
  parameter int KEY_WIDTH = 32,
  parameter int NUM_CELLS = 4
) (
  input  logic clk,
  input  logic reset,
  second_chance_ctrl_if.slave bus
`ifdef SC_STATS_EN
  ,
  output logic [31:0] stat_hit_o,
  output logic [31:0] stat_evict_o
`endif
);
  localparam int IW = $clog2(NUM_CELLS);
  localparam logic [1:0] OP_INS = 2'b01;
  localparam logic [1:0] OP_DEL = 2'b10;

  typedef enum logic [2:0] {IDLE, LOOKUP, SCAN, WRITE, DELETE, RESP} state_t;

  state_t               state;
  logic [1:0]           op_q;
  logic [KEY_WIDTH-1:0] key_q;
  logic [NUM_CELLS-1:0] ref_q;
  logic [IW-1:0]        hand, target;
  logic                 from_scan;
  logic [IW:0]          scan_cnt;

  logic          hit_any, emp_any;
  logic [IW-1:0] hit_idx, emp_idx;

  assign bus.key_read_o  = key_q;
  assign bus.key_write_o = key_q;

  // Lowest-index match / empty cell (scan downward so the lowest wins).
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    emp_any = 1'b0;
    emp_idx = '0;
    for (int i = NUM_CELLS - 1; i >= 0; i--) begin
      if (bus.cell_hit_i[i]) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
      if (bus.cell_empty_i[i]) begin
        emp_any = 1'b1;
        emp_idx = IW'(i);
      end
    end
  end

  function automatic logic [NUM_CELLS-1:0] onehot(input logic [IW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Every output is registered: the strobes for WRITE/DELETE and the
  // response strobe are loaded on the edge that enters that state, so they
  // are high for exactly the one cycle spent there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      op_q             <= '0;
      key_q            <= '0;
      ref_q            <= '0;
      hand             <= '0;
      target           <= '0;
      from_scan        <= 1'b0;
      scan_cnt         <= '0;
      bus.req_ready_o  <= 1'b1;
      bus.resp_valid_o <= 1'b0;
      bus.resp_hit_o   <= 1'b0;
      bus.resp_idx_o   <= '0;
      bus.resp_evict_o <= 1'b0;
      bus.cell_cs_o    <= '0;
      bus.cell_we_o    <= 1'b0;
      bus.cell_del_o   <= 1'b0;
    end else begin
      bus.resp_valid_o <= 1'b0;
      bus.cell_cs_o    <= '0;
      bus.cell_we_o    <= 1'b0;
      bus.cell_del_o   <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid_i && bus.req_ready_o) begin
          op_q            <= bus.req_op_i;
          key_q           <= bus.req_key_i;
          bus.req_ready_o <= 1'b0;
          state           <= LOOKUP;
        end
        LOOKUP: begin
          bus.resp_hit_o   <= hit_any;
          bus.resp_idx_o   <= hit_any ? hit_idx : '0;
          bus.resp_evict_o <= 1'b0;
          from_scan        <= 1'b0;
          scan_cnt         <= '0;
          if (op_q == OP_DEL) begin
            if (hit_any) begin
              target         <= hit_idx;
              bus.cell_cs_o  <= onehot(hit_idx);
              bus.cell_del_o <= 1'b1;
              state          <= DELETE;
            end else begin
              bus.resp_valid_o <= 1'b1;
              state            <= RESP;
            end
          end else if (op_q == OP_INS && !hit_any) begin
            if (emp_any) begin
              target        <= emp_idx;
              bus.cell_cs_o <= onehot(emp_idx);
              bus.cell_we_o <= 1'b1;
              state         <= WRITE;
            end else begin
              state <= SCAN;
            end
          end else begin
            // Lookup (and reserved op) or insert hit: give the cell a second chance.
            if (hit_any) ref_q[hit_idx] <= 1'b1;
            bus.resp_valid_o <= 1'b1;
            state            <= RESP;
          end
        end
        SCAN: begin
          // scan_cnt guards the N+1 cycle bound even if ref bits misbehave.
          if (ref_q[hand] && scan_cnt < (IW+1)'(NUM_CELLS)) begin
            ref_q[hand] <= 1'b0;
            hand        <= hand + IW'(1);
            scan_cnt    <= scan_cnt + (IW+1)'(1);
          end else begin
            target        <= hand;
            from_scan     <= 1'b1;
            bus.cell_cs_o <= onehot(hand);
            bus.cell_we_o <= 1'b1;
            state         <= WRITE;
          end
        end
        WRITE: begin
          ref_q[target] <= 1'b0;
          if (from_scan) hand <= target + IW'(1);
          bus.resp_hit_o   <= 1'b0;
          bus.resp_idx_o   <= target;
          bus.resp_evict_o <= from_scan;
          bus.resp_valid_o <= 1'b1;
          state            <= RESP;
        end
        DELETE: begin
          ref_q[target]    <= 1'b0;
          bus.resp_valid_o <= 1'b1;
          state            <= RESP;
        end
        RESP: begin
          bus.req_ready_o <= 1'b1;
          state           <= IDLE;
        end
        default: begin
          bus.req_ready_o <= 1'b1;
          state           <= IDLE;
        end
      endcase
    end
  end

`ifdef SC_STATS_EN
  // Counted in the RESP cycle, where hit/evict are stable and valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_hit_o   <= '0;
      stat_evict_o <= '0;
    end else if (state == RESP) begin
      if (bus.resp_hit_o && stat_hit_o != '1)     stat_hit_o   <= stat_hit_o + 32'd1;
      if (bus.resp_evict_o && stat_evict_o != '1) stat_evict_o <= stat_evict_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_second_chance_ctrl.sv
// tb_second_chance_ctrl
//   Directed and random operations against second_chance_ctrl with a simple
//   cell-array model attached; results are compared with a behavioural model
//   of the key table, reference bits and clock hand.
module tb_second_chance_ctrl;
  localparam int KW = 32;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  second_chance_ctrl_if #(.KEY_WIDTH(KW), .NUM_CELLS(N)) bus();

`ifdef SC_STATS_EN
  logic [31:0] stat_hit, stat_evict;
  second_chance_ctrl #(.KEY_WIDTH(KW), .NUM_CELLS(N)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .stat_hit_o(stat_hit), .stat_evict_o(stat_evict));
`else
  second_chance_ctrl #(.KEY_WIDTH(KW), .NUM_CELLS(N)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`endif

  // ---------------- cell array attached to the controller ----------------
  logic [KW-1:0] cell_key [N];
  logic [N-1:0]  cell_occ;

  always_comb begin
    bus.cell_hit_i   = '0;
    bus.cell_empty_i = ~cell_occ;
    for (int i = 0; i < N; i++)
      bus.cell_hit_i[i] = cell_occ[i] && (cell_key[i] == bus.key_read_o);
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) cell_occ <= '0;
    else
      for (int i = 0; i < N; i++)
        if (bus.cell_cs_o[i]) begin
          if (bus.cell_we_o) begin
            cell_key[i] <= bus.key_write_o;
            cell_occ[i] <= 1'b1;
          end
          if (bus.cell_del_o) cell_occ[i] <= 1'b0;
        end
  end

  // ---------------- strobe monitor ----------------
  int          we_cnt = 0, del_cnt = 0, rv_cnt = 0;
  logic [N-1:0] last_cs = '0;
  logic        strobe_err = 1'b0;
  always @(negedge clk) begin
    if (bus.cell_we_o) we_cnt <= we_cnt + 1;
    if (bus.cell_del_o) del_cnt <= del_cnt + 1;
    if (bus.resp_valid_o) rv_cnt <= rv_cnt + 1;
    if (bus.cell_we_o || bus.cell_del_o) last_cs <= bus.cell_cs_o;
    if ((bus.cell_we_o && bus.cell_del_o) ||
        (!(bus.cell_we_o || bus.cell_del_o) && bus.cell_cs_o != '0) ||
        ((bus.cell_we_o || bus.cell_del_o) && !$onehot(bus.cell_cs_o)))
      strobe_err <= 1'b1;
  end

  // ---------------- reference model ----------------
  logic [KW-1:0] m_key [N];
  logic [N-1:0]  m_occ, m_ref;
  int            m_hand, m_hits, m_evicts;

  task automatic model_reset();
    m_occ = '0; m_ref = '0; m_hand = 0; m_hits = 0; m_evicts = 0;
  endtask

  // kind: 0 no cell strobe, 1 write, 2 delete
  task automatic model_op(input logic [1:0] op, input logic [KW-1:0] key,
                          output logic e_hit, output int e_idx, output logic e_evict,
                          output int e_lat, output int e_kind);
    int f = -1;
    int e = -1;
    int s = 0;
    for (int i = 0; i < N; i++) begin
      if (f < 0 && m_occ[i] && m_key[i] == key) f = i;
      if (e < 0 && !m_occ[i]) e = i;
    end
    e_hit = (f >= 0); e_idx = (f >= 0) ? f : 0;
    e_evict = 1'b0; e_lat = 2; e_kind = 0;
    if (op == 2'b01) begin
      if (f >= 0) m_ref[f] = 1'b1;
      else begin
        if (e < 0) begin
          while (m_ref[m_hand]) begin
            m_ref[m_hand] = 1'b0; m_hand = (m_hand + 1) % N; s++;
          end
          s++;
          e = m_hand; m_hand = (m_hand + 1) % N; e_evict = 1'b1;
        end
        m_key[e] = key; m_occ[e] = 1'b1; m_ref[e] = 1'b0;
        e_idx = e; e_lat = 3 + s; e_kind = 1;
      end
    end else if (op == 2'b10) begin
      if (f >= 0) begin
        m_occ[f] = 1'b0; m_ref[f] = 1'b0; e_lat = 3; e_kind = 2;
      end
    end else if (f >= 0) m_ref[f] = 1'b1;
    m_hits += int'(e_hit);
    m_evicts += int'(e_evict);
  endtask

  // ---------------- checking ----------------
  int vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [KW-1:0] key,
                       output logic hit, output int idx, output logic evict,
                       output int lat, output logic rv_after);
    int w = 0;
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_op_i = op; bus.req_key_i = key;
    while (!bus.req_ready_o && w < 20) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.resp_valid_o && lat < 30);
    hit = bus.resp_hit_o; idx = int'(bus.resp_idx_o); evict = bus.resp_evict_o;
    @(negedge clk);
    rv_after = bus.resp_valid_o;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [KW-1:0] key);
    logic e_hit, e_evict, hit, evict, rv_after;
    int e_idx, e_lat, e_kind, idx, lat, wc, dc;
    model_op(op, key, e_hit, e_idx, e_evict, e_lat, e_kind);
    wc = we_cnt; dc = del_cnt;
    do_op(op, key, hit, idx, evict, lat, rv_after);
    check({tag, "_lat"}, lat, e_lat);
    check({tag, "_hit"}, hit, e_hit);
    check({tag, "_idx"}, idx, e_idx);
    check({tag, "_evict"}, evict, e_evict);
    check({tag, "_rv_pulse"}, rv_after, 1'b0);
    check({tag, "_we_cnt"}, we_cnt - wc, (e_kind == 1) ? 1 : 0);
    check({tag, "_del_cnt"}, del_cnt - dc, (e_kind == 2) ? 1 : 0);
    if (e_kind != 0) check({tag, "_cs"}, last_cs, 32'(1) << e_idx);
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk); reset = 1'b1;
  endtask

  task automatic fill_table(input string tag);
    for (int i = 0; i < N; i++) run_op(tag, 2'b01, 32'hA0 + i);
  endtask

  task automatic check_stats(input string tag);
`ifdef SC_STATS_EN
    check({tag, "_stat_hit"}, stat_hit, m_hits);
    check({tag, "_stat_evict"}, stat_evict, m_evicts);
`else
    if (tag.len() == 0) $display("no stats");
`endif
  endtask

  initial begin
    int wc, rc;
    bus.req_valid_i = 1'b0; bus.req_op_i = '0; bus.req_key_i = '0;
    model_reset();
    reset = 1'b1;
    #3 reset = 1'b0;
    #1;
    check("rst_resp_valid", bus.resp_valid_o, 1'b0);
    check("rst_resp_hit", bus.resp_hit_o, 1'b0);
    check("rst_resp_idx", bus.resp_idx_o, 0);
    check("rst_resp_evict", bus.resp_evict_o, 1'b0);
    check("rst_strobes", {bus.cell_cs_o, bus.cell_we_o, bus.cell_del_o}, 0);
    check("rst_key", bus.key_read_o, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready", bus.req_ready_o, 1'b1);

    // Fill four empty cells, then lookup + insert with a single-step scan.
    fill_table("fill");
    run_op("lookup_a1", 2'b00, 32'hA1);
    run_op("insert_b0", 2'b01, 32'hB0);
    check("hand_after_b0", m_hand, 1);

    // All reference bits set: scan walks the full clock and wraps to cell 0.
    apply_reset();
    fill_table("fill2");
    for (int i = 0; i < N; i++) run_op("lookup_all", 2'b00, 32'hA0 + i);
    run_op("insert_c0", 2'b01, 32'hC0);

    // Delete hit / miss, then refill the hole without eviction.
    run_op("del_a2", 2'b10, 32'hA2);
    run_op("del_ff", 2'b10, 32'hFF);
    run_op("insert_d0", 2'b01, 32'hD0);
    run_op("reserved_op", 2'b11, 32'hD0);
    check_stats("directed");

    // Random traffic over a small key pool so hits, deletes and scans mix.
    for (int n = 0; n < 150; n++)
      run_op("rand", 2'($urandom_range(0, 3)), 32'hA0 + $urandom_range(0, 7));
    for (int i = 0; i < N; i++) begin
      check("rand_occ", cell_occ[i], m_occ[i]);
      if (m_occ[i]) check("rand_key", cell_key[i], m_key[i]);
    end
    check_stats("random");

    // Reset in the middle of a scan aborts the insert.
    apply_reset();
    fill_table("fill3");
    for (int i = 0; i < N; i++) run_op("lookup_all3", 2'b00, 32'hA0 + i);
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_op_i = 2'b01; bus.req_key_i = 32'hC0;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    wc = we_cnt; rc = rv_cnt;
    reset = 1'b0;
    #1;
    check("scanrst_resp_valid", bus.resp_valid_o, 1'b0);
    check("scanrst_strobes", {bus.cell_cs_o, bus.cell_we_o, bus.cell_del_o}, 0);
    check("scanrst_resp", {bus.resp_hit_o, bus.resp_evict_o, bus.resp_idx_o}, 0);
    model_reset();
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("scanrst_ready", bus.req_ready_o, 1'b1);
    repeat (10) @(negedge clk);
    check("scanrst_no_we", we_cnt - wc, 0);
    check("scanrst_no_resp", rv_cnt - rc, 0);
    run_op("post_rst_insert", 2'b01, 32'hE0);
    check_stats("final");
    check("strobe_rules", strobe_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/second_chance_ctrl.md
SECOND_CHANCE_CTRL -- requirements
Module: second_chance_ctrl

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 32, key width in bits.
REQ-002 SHALL have parameter NUM_CELLS, default 4, number of key cells managed (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid_i  input  1  request present.
REQ-006 SHALL have port req_op_i  input  2  00 lookup, 01 insert, 10 delete, 11 reserved (treated as lookup).
REQ-007 SHALL have port req_key_i  input  KEY_WIDTH  request key.
REQ-008 SHALL have port req_ready_o  output  1  controller can accept a request.
REQ-009 SHALL have port resp_valid_o  output  1  one-cycle response strobe.
REQ-010 SHALL have port resp_hit_o  output  1  key was present before the operation.
REQ-011 SHALL have port resp_idx_o  output  $clog2(NUM_CELLS)  cell index touched.
REQ-012 SHALL have port resp_evict_o  output  1  insert overwrote an occupied cell.
REQ-013 SHALL have port cell_empty_i  input  NUM_CELLS  per-cell empty flags.
REQ-014 SHALL have port cell_hit_i  input  NUM_CELLS  per-cell read-match flags (key_read_o equals stored key, cell occupied).
REQ-015 SHALL have ports cell_cs_o  output  NUM_CELLS  one-hot select; cell_we_o, cell_del_o  output  1 each; key_write_o, key_read_o  output  KEY_WIDTH.

Function
REQ-016 SHALL implement FSM states IDLE, LOOKUP, SCAN, WRITE, DELETE, RESP; req_ready_o=1 only in IDLE.
REQ-017 SHALL accept a request when req_valid_i & req_ready_o, capturing op and key into key_q and moving to LOOKUP.
REQ-018 SHALL drive key_read_o = key_write_o = key_q continuously.
REQ-019 SHALL in LOOKUP sample cell_hit_i and cell_empty_i; multiple hits resolve to lowest index.
REQ-020 SHALL for lookup: hit sets that cell's reference bit; go to RESP (response 2 cycles after accept).
REQ-021 SHALL for insert with hit: set reference bit, no write, RESP with resp_hit_o=1.
REQ-022 SHALL for insert with miss and any empty cell: target lowest-index empty cell, go to WRITE.
REQ-023 SHALL for insert with miss and no empty cell: go to SCAN; each SCAN cycle examines cell at hand: ref=1 -> clear it, hand+1 mod NUM_CELLS; ref=0 -> victim=hand, go to WRITE.
REQ-024 SHALL bound SCAN to at most NUM_CELLS+1 cycles.
REQ-025 SHALL in WRITE assert cell_cs_o=onehot(target), cell_we_o=1 for exactly one cycle, clear target ref bit, set hand=target+1 mod NUM_CELLS only when target came from SCAN, then RESP with resp_evict_o=1 iff target came from SCAN.
REQ-026 SHALL for delete with hit: DELETE asserts cell_cs_o=onehot(idx), cell_del_o=1 one cycle, clears ref bit, then RESP; delete miss goes straight to RESP with resp_hit_o=0.
REQ-027 SHALL in RESP assert resp_valid_o for one cycle with hit/idx/evict, then return to IDLE; resp_idx_o=0 on lookup/delete miss.
REQ-028 SHALL keep cell_cs_o=0, cell_we_o=0, cell_del_o=0 in all states other than WRITE/DELETE; never assert we and del together.
REQ-029 SHALL ignore req_valid_i outside IDLE (no queuing; requester holds valid until ready).

Reset
REQ-030 SHALL on reset low immediately force state IDLE, ref bits 0, hand 0, key_q 0, resp_valid_o/resp_hit_o/resp_evict_o/resp_idx_o 0, cell strobes 0.
REQ-031 SHALL abort any in-flight operation on reset with no further cell strobe or response; req_ready_o=1 the first cycle after release.

Configuration
REQ-032 SHALL with SC_STATS_EN defined add outputs stat_hit_o, stat_evict_o (32 bits each), incremented on each RESP with hit / evict, saturating at all-ones, cleared by reset.
REQ-033 SHALL without SC_STATS_EN omit those ports and counters; all other behaviour identical.

Verification (NUM_CELLS=4, KEY_WIDTH=32, cell models attached)
REQ-034 SHALL check: reset, insert 0xA0,0xA1,0xA2,0xA3 -> writes to cells 0,1,2,3, resp_hit=0, evict=0, each response 3 cycles after accept.
REQ-035 SHALL check: full table, lookup 0xA1 then insert 0xB0 -> lookup hit idx1; insert evicts cell 0 (ref 0), hand=1, evict=1.
REQ-036 SHALL check: full table, lookups hit cells 0..3 (all ref=1), insert 0xC0 -> SCAN clears all four ref bits, victim cell 0, SCAN lasts 5 cycles.
REQ-037 SHALL check: delete 0xA2 present -> cell_del pulse on cell 2, hit=1; delete 0xFF absent -> no strobe, hit=0; next insert 0xD0 fills cell 2 with evict=0.
REQ-038 SHALL check: reset asserted during SCAN -> no cell_we pulse, no resp_valid, outputs 0 asynchronously, ready=1 after release.
REQ-039 SHALL check with SC_STATS_EN: sequence above -> stat_hit_o and stat_evict_o match counted hits/evictions.
